// File: rtl/read_port_pkg.sv
// Definitions shared by the read and write ports of the memory.
// Holds the port state encoding and the default address and data widths.
package read_port_pkg;

  localparam int DEFAULT_ADDRESS_WIDTH = 8;
  localparam int DEFAULT_DATA_WIDTH    = 32;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_FETCH   = 2'd1,
    ST_CAPTURE = 2'd2
  } port_state_e;

endpackage

// File: rtl/read_port_addr_counter.sv
// Address pointer that can be loaded or incremented, and wraps at the top of its range.
// The read side and the write side both use this pointer.
module addr_counter
  import read_port_pkg::*;
#(
  parameter int WIDTH = DEFAULT_ADDRESS_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_addr,
  input  logic             incr,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_d;
  logic [WIDTH-1:0] count_q;

  // Load takes priority over increment. Incrementing from all ones wraps to zero.
  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_addr;
    end else if (incr) begin
      count_d = count_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/read_port.sv
// Read port that fetches one word per accepted start through an IDLE/FETCH/CAPTURE sequence.
// The port tracks emptiness by comparing its read pointer with the writer's pointer.
module read_port
  import read_port_pkg::*;
#(
  parameter int ADDRESS_WIDTH = DEFAULT_ADDRESS_WIDTH,
  parameter int DATA_WIDTH    = DEFAULT_DATA_WIDTH
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic                     load,
  input  logic [ADDRESS_WIDTH-1:0] load_addr,
  input  logic [ADDRESS_WIDTH-1:0] wr_ptr,
  output logic                     mem_rd_en,
  output logic [ADDRESS_WIDTH-1:0] mem_addr,
  input  logic [DATA_WIDTH-1:0]    mem_rdata,
  output logic                     ready,
  output logic [DATA_WIDTH-1:0]    data,
  output logic                     valid,
  output logic                     empty
);

  port_state_e             state_d, state_q;
  logic [DATA_WIDTH-1:0]   data_d, data_q;
  logic                    valid_d, valid_q;
  logic                    load_ptr;
  logic                    incr_ptr;
  logic [ADDRESS_WIDTH-1:0] rd_ptr;

  addr_counter #(
    .WIDTH(ADDRESS_WIDTH)
  ) u_rd_ptr (
    .clk      (clk),
    .reset    (reset),
    .load     (load_ptr),
    .load_addr(load_addr),
    .incr     (incr_ptr),
    .count    (rd_ptr)
  );

  // Once a read leaves IDLE, it always runs to completion. Reset is the only way to abort it.
  always_comb begin
    state_d   = state_q;
    data_d    = data_q;
    valid_d   = 1'b0;
    load_ptr  = 1'b0;
    incr_ptr  = 1'b0;
    mem_rd_en = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (load) begin
          load_ptr = 1'b1;
        end else if (start && !empty) begin
          state_d = ST_FETCH;
        end
      end
      ST_FETCH: begin
        mem_rd_en = 1'b1;
        state_d   = ST_CAPTURE;
      end
      ST_CAPTURE: begin
        data_d   = mem_rdata;
        valid_d  = 1'b1;
        incr_ptr = 1'b1;
        state_d  = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  assign mem_addr = rd_ptr;
  assign empty    = (rd_ptr == wr_ptr);
  assign ready    = (state_q == ST_IDLE);
  assign data     = data_q;
  assign valid    = valid_q;

endmodule

// File: tb/tb_read_port.sv
// Testbench for read_port. A transaction-level model is checked on every cycle.
// The bench also runs directed scenarios with literal expectations, followed by random traffic.
module tb_read_port;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        load;
  logic [7:0]  load_addr;
  logic [7:0]  wr_ptr;
  logic        mem_rd_en;
  logic [7:0]  mem_addr;
  logic [31:0] mem_rdata;
  logic        ready;
  logic [31:0] data;
  logic        valid;
  logic        empty;

  int n_vectors = 0;
  int n_miscompares = 0;
  int cyc = 0;

  logic [31:0] mem [256];

  // Model of the port as a read transaction in flight.
  logic [7:0]  m_ptr;
  logic [31:0] m_data;
  int          m_left;
  bit          m_valid;
  bit          m_live = 1'b0;

  int          valid_cnt = 0;
  int          rd_en_cnt = 0;
  logic [31:0] seen_data[$];
  int          seen_cyc[$];
  logic [7:0]  rd_addrs[$];

  read_port dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .load     (load),
    .load_addr(load_addr),
    .wr_ptr   (wr_ptr),
    .mem_rd_en(mem_rd_en),
    .mem_addr (mem_addr),
    .mem_rdata(mem_rdata),
    .ready    (ready),
    .data     (data),
    .valid    (valid),
    .empty    (empty)
  );

  always #5 clk = ~clk;

  // The memory returns data one cycle after mem_rd_en. On other cycles it returns garbage.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    mem_rdata <= mem_rd_en ? mem[mem_addr] : $urandom;
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vectors++;
    if (act !== exp) begin
      n_miscompares++;
      $display("[TB] FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic s, input logic l, input logic [7:0] la,
                               input logic [7:0] wp, input logic r);
    @(negedge clk);
    start = s;
    load = l;
    load_addr = la;
    wr_ptr = wp;
    reset = r;
  endtask

  task automatic clearMonitor();
    valid_cnt = 0;
    rd_en_cnt = 0;
    seen_data.delete();
    seen_cyc.delete();
    rd_addrs.delete();
  endtask

  // When a read is accepted, the port spends one cycle strobing memory and one cycle capturing.
  // On the following edge, the word and the pointer advance take effect.
  always @(posedge clk) begin
    if (reset) begin
      m_ptr = 8'd0;
      m_data = 32'd0;
      m_left = 0;
      m_valid = 1'b0;
      m_live = 1'b1;
    end else if (m_live) begin
      m_valid = 1'b0;
      if (m_left == 2) begin
        m_left = 1;
      end else if (m_left == 1) begin
        m_data = mem[m_ptr];
        m_ptr = m_ptr + 8'd1;
        m_valid = 1'b1;
        m_left = 0;
      end else if (load) begin
        m_ptr = load_addr;
      end else if (start && (m_ptr != wr_ptr)) begin
        m_left = 2;
      end
    end
  end

  always @(posedge clk) begin
    #1;
    if (m_live) begin
      checkOutput("ready", 32'(ready), 32'(m_left == 0));
      checkOutput("mem_rd_en", 32'(mem_rd_en), 32'(m_left == 2));
      checkOutput("mem_addr", 32'(mem_addr), 32'(m_ptr));
      checkOutput("valid", 32'(valid), 32'(m_valid));
      checkOutput("data", data, m_data);
      checkOutput("empty", 32'(empty), 32'(m_ptr == wr_ptr));
    end
    if (valid) begin
      valid_cnt++;
      seen_data.push_back(data);
      seen_cyc.push_back(cyc);
    end
    if (mem_rd_en) begin
      rd_en_cnt++;
      rd_addrs.push_back(mem_addr);
    end
  end

  initial begin
    logic [7:0] wp;
    for (int i = 0; i < 256; i++) begin
      mem[i] = (i < 3) ? 32'(i) : (32'hC0DE_0000 | 32'(i));
    end
    start = 0; load = 0; load_addr = 0; wr_ptr = 0; reset = 1;
    applyStimulus(0, 0, 8'h00, 8'h00, 1);
    applyStimulus(0, 0, 8'h00, 8'h00, 1);
    applyStimulus(0, 0, 8'h00, 8'h03, 0);
    #2;
    checkOutput("reset_ready", 32'(ready), 32'd1);
    checkOutput("reset_data", data, 32'd0);
    checkOutput("reset_valid", 32'(valid), 32'd0);
    checkOutput("reset_addr", 32'(mem_addr), 32'd0);

    // Three words are read back to back. After that, the port is empty and stops reading.
    clearMonitor();
    repeat (14) applyStimulus(1, 0, 8'h00, 8'h03, 0);
    applyStimulus(0, 0, 8'h00, 8'h03, 0);
    checkOutput("b2b_valid_count", 32'(valid_cnt), 32'd3);
    checkOutput("b2b_rd_count", 32'(rd_en_cnt), 32'd3);
    if (valid_cnt == 3) begin
      checkOutput("b2b_word0", seen_data[0], 32'd0);
      checkOutput("b2b_word1", seen_data[1], 32'd1);
      checkOutput("b2b_word2", seen_data[2], 32'd2);
      checkOutput("b2b_spacing", 32'(seen_cyc[1] - seen_cyc[0]), 32'd3);
      checkOutput("b2b_spacing2", 32'(seen_cyc[2] - seen_cyc[1]), 32'd3);
    end
    checkOutput("b2b_empty", 32'(empty), 32'd1);

    // Load FF, then read twice. The pointer wraps through 00 and ends at 01.
    clearMonitor();
    applyStimulus(0, 1, 8'hFF, 8'h01, 0);
    applyStimulus(1, 0, 8'h00, 8'h01, 0);
    repeat (3) applyStimulus(0, 0, 8'h00, 8'h01, 0);
    applyStimulus(1, 0, 8'h00, 8'h01, 0);
    repeat (3) applyStimulus(0, 0, 8'h00, 8'h01, 0);
    checkOutput("wrap_rd_count", 32'(rd_en_cnt), 32'd2);
    if (rd_en_cnt == 2) begin
      checkOutput("wrap_addr0", 32'(rd_addrs[0]), 32'h00FF);
      checkOutput("wrap_addr1", 32'(rd_addrs[1]), 32'h0000);
      checkOutput("wrap_data0", seen_data[0], 32'hC0DE_00FF);
    end
    checkOutput("wrap_ptr", 32'(mem_addr), 32'h01);
    checkOutput("wrap_empty", 32'(empty), 32'd1);

    // When load and start arrive together, the load wins and the start is ignored.
    clearMonitor();
    applyStimulus(1, 1, 8'h05, 8'h09, 0);
    @(posedge clk); #2;
    checkOutput("both_no_rd", 32'(mem_rd_en), 32'd0);
    checkOutput("both_ptr", 32'(mem_addr), 32'h05);
    applyStimulus(1, 0, 8'h00, 8'h09, 0);
    repeat (3) applyStimulus(0, 0, 8'h00, 8'h09, 0);
    checkOutput("both_rd_count", 32'(rd_en_cnt), 32'd1);
    if (rd_en_cnt == 1) checkOutput("both_addr", 32'(rd_addrs[0]), 32'h05);
    checkOutput("both_data", data, 32'hC0DE_0005);

    // Reset during CAPTURE aborts the read.
    clearMonitor();
    applyStimulus(1, 0, 8'h00, 8'h09, 0);
    applyStimulus(0, 0, 8'h00, 8'h09, 0);
    applyStimulus(0, 0, 8'h00, 8'h09, 1);
    @(posedge clk); #2;
    checkOutput("abort_valid", 32'(valid), 32'd0);
    checkOutput("abort_data", data, 32'd0);
    checkOutput("abort_ptr", 32'(mem_addr), 32'd0);
    checkOutput("abort_ready", 32'(ready), 32'd1);
    applyStimulus(0, 0, 8'h00, 8'h09, 0);
    applyStimulus(0, 0, 8'h00, 8'h09, 0);
    checkOutput("abort_valid_count", 32'(valid_cnt), 32'd0);

    // A start held through FETCH and CAPTURE produces only one read.
    clearMonitor();
    repeat (3) applyStimulus(1, 0, 8'h00, 8'h0A, 0);
    repeat (4) applyStimulus(0, 0, 8'h00, 8'h0A, 0);
    checkOutput("busy_valid_count", 32'(valid_cnt), 32'd1);
    checkOutput("busy_rd_count", 32'(rd_en_cnt), 32'd1);

    // Random traffic checked against the model.
    wp = 8'h08;
    for (int i = 0; i < 3000; i++) begin
      logic s, l, r;
      logic [7:0] la;
      if ($urandom_range(0, 9) == 0) wp = 8'($urandom_range(0, 15));
      s = ($urandom_range(0, 3) != 0);
      l = ($urandom_range(0, 15) == 0);
      la = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(0, 15)) : 8'($urandom_range(250, 255));
      r = ($urandom_range(0, 99) == 0);
      applyStimulus(s, l, la, wp, r);
    end
    applyStimulus(0, 0, 8'h00, wp, 0);
    applyStimulus(0, 0, 8'h00, wp, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
    $finish;
  end

endmodule

// File: doc/read_port.md
READ_PORT -- requirements
Module: read_port

Interface
REQ-001 SHALL have parameter ADDRESS_WIDTH, default 8, width of read pointer and memory address.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, width of memory word and data output.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port start  input  1  request to read one word; sampled only in IDLE.
REQ-006 SHALL have port load  input  1  load read pointer from load_addr; sampled only in IDLE.
REQ-007 SHALL have port load_addr  input  ADDRESS_WIDTH  new read pointer value.
REQ-008 SHALL have port wr_ptr  input  ADDRESS_WIDTH  writer's next-write address, used for empty detection.
REQ-009 SHALL have port mem_rd_en  output  1  memory read strobe.
REQ-010 SHALL have port mem_addr  output  ADDRESS_WIDTH  memory read address.
REQ-011 SHALL have port mem_rdata  input  DATA_WIDTH  memory read data, valid one cycle after mem_rd_en.
REQ-012 SHALL have port ready  output  1  high in IDLE only.
REQ-013 SHALL have port data  output  DATA_WIDTH  last word read; held until next read completes.
REQ-014 SHALL have port valid  output  1  one-cycle pulse when data is updated.
REQ-015 SHALL have port empty  output  1  combinational: rd_ptr == wr_ptr.

Function
REQ-016 SHALL implement states IDLE, FETCH, CAPTURE.
REQ-017 IDLE: load=1 -> rd_ptr <= load_addr, stay IDLE; else start=1 and empty=0 -> FETCH; else stay IDLE.
REQ-018 FETCH: mem_rd_en=1, mem_addr=rd_ptr for exactly one cycle; next state CAPTURE.
REQ-019 CAPTURE: at the closing edge data <= mem_rdata, valid <= 1, rd_ptr <= rd_ptr+1; next state IDLE.
REQ-020 Latency: start sampled at edge N -> FETCH in cycle N+1, CAPTURE in N+2, valid=1 and ready=1 in N+3.
REQ-021 Back-to-back: start held high gives one word every 3 cycles while not empty.
REQ-022 mem_rd_en SHALL be 0 and mem_addr SHALL equal rd_ptr outside FETCH.
REQ-023 rd_ptr SHALL wrap modulo 2^ADDRESS_WIDTH (all-ones +1 -> 0).
REQ-024 load and start both high in IDLE: load wins, start ignored that cycle.
REQ-025 start with empty=1 SHALL be ignored; no memory access, no valid.
REQ-026 start/load outside IDLE SHALL be ignored; a started read always completes.
REQ-027 empty SHALL track wr_ptr changes immediately; the in-flight read is not aborted.

Reset
REQ-028 reset=1 at an edge: state IDLE, rd_ptr 0, data 0, valid 0; mem_rd_en 0, ready 1 from next cycle.
REQ-029 reset SHALL take priority over load/start and abort any in-flight read (no valid, rd_ptr not incremented).

Structure
REQ-030 State encoding and default ADDRESS_WIDTH/DATA_WIDTH constants SHALL live in the shared package used by the writer.
REQ-031 rd_ptr with load/increment/wrap SHALL be a sub-module addr_counter, reusable by the writer side.

Verification
REQ-032 Reset, then wr_ptr=3, mem holds 0,1,2 at addr 0..2, start held high -> valid pulses with data 0,1,2 at 3-cycle spacing, then empty=1 and no further mem_rd_en.
REQ-033 load_addr=8'hFF, load=1, wr_ptr=8'h01, two starts -> reads addr FF then 00, rd_ptr ends 01, empty=1.
REQ-034 load=1 and start=1 same IDLE cycle, load_addr=5 -> rd_ptr=5, no mem_rd_en that cycle; next start reads addr 5.
REQ-035 reset asserted during CAPTURE -> valid stays 0, data=0, rd_ptr=0, ready=1 next cycle.
REQ-036 start pulsed during FETCH/CAPTURE with data available -> ignored; exactly one valid per accepted start.
